// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage: order codes, FSM state
// encoding and the order -> byte-count helper.
package mem_access_unit_pkg;

    localparam logic [5:0] ORD_LB  = 6'h01;
    localparam logic [5:0] ORD_LH  = 6'h02;
    localparam logic [5:0] ORD_LW  = 6'h03;
    localparam logic [5:0] ORD_LBU = 6'h04;
    localparam logic [5:0] ORD_LHU = 6'h05;
    localparam logic [5:0] ORD_SB  = 6'h08;
    localparam logic [5:0] ORD_SH  = 6'h09;
    localparam logic [5:0] ORD_SW  = 6'h0A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Zero marks an order that performs no memory access.
    function automatic logic [2:0] byte_count(input logic [5:0] order);
        case (order)
            ORD_LB, ORD_LBU, ORD_SB: return 3'd1;
            ORD_LH, ORD_LHU, ORD_SH: return 3'd2;
            ORD_LW, ORD_SW:          return 3'd4;
            default:                 return 3'd0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] order);
        return (order == ORD_SB) || (order == ORD_SH) || (order == ORD_SW);
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Sequential load/store stage over a byte-wide RAM port; loads are packed
// little-endian and zero-filled. Optional alignment trap: MEM_ALIGN_CHECK_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W            = 32,
    parameter bit FLUSH_KEEPS_STORE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    // req_valid/req_ready: a request transfers on a rising edge where both are
    // high and flush is low; upstream holds req_* stable until that edge.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_order,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    output logic              done_valid,
    output logic [5:0]        done_order,
    output logic [31:0]       done_data,
    output logic              misalign
);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cnt;
    logic [5:0]        order_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;
    logic [2:0]        req_n;
    logic [2:0]        cur_n;
    logic [1:0]        rd_idx;
    logic              accept;
    logic              mis_req;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready && !flush;
    assign req_n     = byte_count(req_order);
    assign cur_n     = byte_count(order_q);
    // RAM data lags its address by one cycle, so READ step k stores byte k-1.
    assign rd_idx    = cnt[1:0] - 2'd1;

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q;

    assign mis_req = ((req_n == 3'd2) && req_addr[0]) ||
                     ((req_n == 3'd4) && (req_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= mis_req;
        end
    end

    assign misalign = (state == ST_DONE) && mis_q;
`else
    assign mis_req  = 1'b0;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (mis_req || (req_n == 3'd0)) begin
                        state_nxt = ST_DONE;
                    end else if (is_store(req_order)) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == cur_n) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (flush && !FLUSH_KEEPS_STORE) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == cur_n - 3'd1) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 3'd0;
            order_q <= 6'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
        end else if (accept) begin
            cnt     <= 3'd0;
            order_q <= req_order;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            data_q  <= 32'd0;
        end else if (state == ST_READ) begin
            cnt <= cnt + 3'd1;
            if (cnt != 3'd0) begin
                data_q[{rd_idx, 3'b000} +: 8] <= mem_din;
            end
        end else if (state == ST_WRITE) begin
            cnt <= cnt + 3'd1;
        end
    end

    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = 8'd0;
        if ((state == ST_READ) || (state == ST_WRITE)) begin
            mem_a = addr_q + ADDR_W'(cnt);
        end
        if (state == ST_WRITE) begin
            mem_wr   = 1'b1;
            mem_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
        end
    end

    // Flush in the DONE cycle cancels the completion the downstream would see.
    assign done_valid = (state == ST_DONE) && !flush;
    assign done_order = order_q;
    assign done_data  = data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a cycle-indexed behavioural model plus
// literal pins on the headline transactions.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_order;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        done_valid;
    logic [5:0]  done_order;
    logic [31:0] done_data;
    logic        misalign;

    mem_access_unit #(.ADDR_W(32), .FLUSH_KEEPS_STORE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_order(req_order),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
        .done_valid(done_valid), .done_order(done_order), .done_data(done_data),
        .misalign(misalign)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RAM environment (4 KiB, low address bits) ----------------
    logic [7:0]  ram [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_a  = 12'd0;
    logic [7:0]  pl_d  = 8'd0;

    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (pl_en) ram[pl_a] <= pl_d;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end

    // ---------------- model state / scoreboard ----------------
    typedef struct { logic wr; logic [31:0] a; logic [7:0] d; } acc_t;
    typedef struct { logic [5:0] ord; logic mis; } done_t;

    acc_t        acc_m  [int];
    done_t       done_m [int];
    bit          busy_m [int];
    logic [31:0] exp_q  [$];
    logic [7:0]  mdl_ram [0:4095];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int obs_n   = 0;
    int obs_cyc = 0;
    logic [31:0] obs_data = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int nbytes_m(input logic [5:0] o);
        if (o == ORD_LB || o == ORD_LBU || o == ORD_SB) return 1;
        if (o == ORD_LH || o == ORD_LHU || o == ORD_SH) return 2;
        if (o == ORD_LW || o == ORD_SW) return 4;
        return 0;
    endfunction

    function automatic bit misal_m(input logic [5:0] o, input logic [31:0] a);
        int n;
        n = nbytes_m(o);
`ifdef MEM_ALIGN_CHECK_EN
        return ((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00));
`else
        return (n < 0) && a[0];
`endif
    endfunction

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        mdl_ram[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Called 1 time unit after a rising edge with the DUT idle. fl_off / rs_off
    // are cycle offsets from the presenting cycle (-1 = none).
    task automatic issue(input logic [5:0] ord, input logic [31:0] addr,
                         input logic [31:0] wd, input int fl_off, input int rs_off,
                         output int t_acc);
        int t, n, last;
        bit st, mis, kill;
        logic [31:0] data, ak, sh;
        t = cyc;
        t_acc = t;
        n = nbytes_m(ord);
        st = (ord == ORD_SB || ord == ORD_SH || ord == ORD_SW);
        mis = misal_m(ord, addr);
        if (mis) n = 0;
        last = (n == 0) ? t + 1 : (st ? t + n + 1 : t + n + 2);
        data = 32'd0;
        for (int c = t + 1; c <= last; c++) busy_m[c] = 1'b1;
        for (int k = 0; k < n; k++) begin
            ak = addr + 32'(k);
            sh = wd >> (8 * k);
            acc_m[t + 1 + k] = '{wr: st, a: ak, d: (st ? sh[7:0] : 8'h00)};
            if (!st) data = data | (32'(mdl_ram[ak[11:0]]) << (8 * k));
        end
        kill = 1'b0;
        if (fl_off >= 0 && !(st && (t + fl_off < last))) begin
            kill = 1'b1;
            for (int c = t + fl_off + 1; c <= last; c++) begin
                busy_m.delete(c); acc_m.delete(c);
            end
        end
        if (rs_off >= 0) begin
            kill = 1'b1;
            for (int c = t + rs_off; c <= last; c++) begin
                busy_m.delete(c); acc_m.delete(c);
            end
        end
        if (!kill) begin
            done_m[last] = '{ord: ord, mis: mis};
            exp_q.push_back(data);
        end

        req_valid = 1'b1; req_order = ord; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = t + 1; c <= last; c++) begin
            flush = (fl_off >= 0) && (c == t + fl_off);
            if (rs_off >= 0 && c == t + rs_off) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_mid_mem_wr", mem_wr, 1'b0);
                chk("rst_mid_req_ready", req_ready, 1'b1);
                chk("rst_mid_done_valid", done_valid, 1'b0);
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic pin(input string nm, input int t, input int n0,
                       input logic [31:0] d, input int lat);
        chk({nm, "_count"}, 32'(obs_n - n0), 32'd1);
        chk({nm, "_data"}, obs_data, d);
        chk({nm, "_latency"}, 32'(obs_cyc - t), 32'(lat));
    endtask

    // ---------------- compare process ----------------
    initial begin
        int c;
        bit ew, dv;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                c  = cyc;
                ew = acc_m.exists(c) && acc_m[c].wr;
                dv = done_m.exists(c);
                chk("req_ready", req_ready, !busy_m.exists(c));
                chk("mem_wr", mem_wr, ew);
                if (acc_m.exists(c)) chk("mem_a", mem_a, acc_m[c].a);
                if (ew) begin
                    chk("mem_dout", mem_dout, acc_m[c].d);
                    mdl_ram[acc_m[c].a[11:0]] = acc_m[c].d;
                end
                chk("done_valid", done_valid, dv);
                chk("misalign", misalign, dv && done_m[c].mis);
                if (dv) begin
                    ed = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                    chk("done_data", done_data, ed);
                    chk("done_order", done_order, done_m[c].ord);
                end
                if (done_valid) begin
                    obs_n++;
                    obs_cyc  = c;
                    obs_data = done_data;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t, n0;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0;
        req_order = 6'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 4096; i++) mdl_ram[i] = 8'h00;

        preload(12'h100, 8'h78); preload(12'h101, 8'h56);
        preload(12'h102, 8'h34); preload(12'h103, 8'h12);
        preload(12'h104, 8'h9A); preload(12'h040, 8'h80);
        preload(12'h200, 8'h00); preload(12'h201, 8'h00); preload(12'h204, 8'h00);
        preload(12'hFFF, 8'h34); preload(12'h000, 8'h12);
        preload(12'h120, 8'h11); preload(12'h121, 8'h22);
        preload(12'h122, 8'h33); preload(12'h123, 8'h44);
        preload(12'h140, 8'hAA); preload(12'h141, 8'hBB);
        preload(12'h142, 8'hCC); preload(12'h143, 8'hDD);
        for (int i = 0; i < 4; i++) preload(12'h300 + 12'(i), 8'h00);

        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", mem_dout, 8'd0);
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_done_order", done_order, 6'd0);
        chk("rst_done_data", done_data, 32'd0);
        chk("rst_misalign", misalign, 1'b0);

        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        n0 = obs_n; issue(ORD_LW, 32'h100, 32'd0, -1, -1, t);
        pin("lw_100", t, n0, 32'h1234_5678, 6);

        n0 = obs_n; issue(ORD_LB, 32'h40, 32'd0, -1, -1, t);
        pin("lb_40", t, n0, 32'h0000_0080, 3);

        n0 = obs_n; issue(ORD_SH, 32'h200, 32'h0000_BEEF, -1, -1, t);
        pin("sh_200", t, n0, 32'd0, 3);
        chk("sh_ram_200", ram[12'h200], 8'hEF);
        chk("sh_ram_201", ram[12'h201], 8'hBE);

        n0 = obs_n; issue(ORD_LH, 32'hFFFF_FFFF, 32'd0, -1, -1, t);
`ifdef MEM_ALIGN_CHECK_EN
        pin("lh_wrap", t, n0, 32'd0, 1);
`else
        pin("lh_wrap", t, n0, 32'h0000_1234, 4);
`endif

        n0 = obs_n; issue(ORD_LW, 32'h120, 32'd0, 2, -1, t);
        chk("lw_flush_count", 32'(obs_n - n0), 32'd0);

        n0 = obs_n; issue(ORD_LW, 32'h140, 32'd0, -1, -1, t);
        pin("lw_after_flush", t, n0, 32'hDDCC_BBAA, 6);

        n0 = obs_n;
        req_valid = 1'b1; req_order = ORD_LW; req_addr = 32'h100; flush = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", 32'(obs_n - n0), 32'd0);

        n0 = obs_n; issue(ORD_LBU, 32'h40, 32'd0, 3, -1, t);
        chk("flush_in_done_count", 32'(obs_n - n0), 32'd0);

        n0 = obs_n; issue(ORD_SB, 32'h204, 32'h0000_005A, 1, -1, t);
        pin("sb_flush_kept", t, n0, 32'd0, 2);
        chk("sb_ram_204", ram[12'h204], 8'h5A);

        n0 = obs_n; issue(6'h3F, 32'h100, 32'd0, -1, -1, t);
        pin("bad_order", t, n0, 32'd0, 1);

        n0 = obs_n; issue(ORD_SW, 32'h300, 32'hCAFE_F00D, -1, 2, t);
        chk("sw_reset_count", 32'(obs_n - n0), 32'd0);
        n0 = obs_n; issue(ORD_LW, 32'h300, 32'd0, -1, -1, t);
        pin("lw_partial", t, n0, 32'h0000_000D, 6);

        n0 = obs_n; issue(ORD_SW, 32'h300, 32'h89AB_CDEF, -1, -1, t);
        pin("sw_full", t, n0, 32'd0, 5);
        n0 = obs_n; issue(ORD_LW, 32'h300, 32'd0, -1, -1, t);
        pin("lw_full", t, n0, 32'h89AB_CDEF, 6);

        n0 = obs_n; issue(ORD_LHU, 32'h103, 32'd0, -1, -1, t);
`ifdef MEM_ALIGN_CHECK_EN
        pin("lhu_odd", t, n0, 32'd0, 1);
`else
        pin("lhu_odd", t, n0, 32'h0000_9A12, 4);
`endif

        repeat (3) begin @(posedge clk); #1; end
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
